// File: rtl/dm_cache_pkg.sv
// Shared widths, FSM state encoding, request payload and address-split helpers
// for the direct-mapped write-back cache controller.
package dm_cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INDEX_W    = 10;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned NUM_LINES  = 1 << INDEX_W;
  localparam int unsigned WSEL_W     = OFFSET_W - 2;
  localparam int unsigned LINE_BIT_W = $clog2(LINE_W);
  localparam int unsigned WORD_SH    = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } cpu_req_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WSEL_W];
  endfunction

endpackage

// File: rtl/dm_cache_controller_tag_store.sv
// Per-line tag array (not reset) plus valid/dirty vectors cleared by async reset.
// Combinational read and a single write port with independent field enables.
module cache_tag_store
  import dm_cache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] index_i,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               valid_we_i,
  input  logic               valid_i,
  input  logic               dirty_we_i,
  input  logic               dirty_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o
);

  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[index_i] <= tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (valid_we_i) begin
      valid_q[index_i] <= valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_q <= '0;
    end else if (dirty_we_i) begin
      dirty_q[index_i] <= dirty_i;
    end
  end

  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: tag lookup,
// dirty-victim writeback and line refill over a 128-bit valid/ready memory port.
module dm_cache_controller
  import dm_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [WORD_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [WORD_W-1:0] cpu_resp_rdata,
  output logic [INDEX_W-1:0] ds_index,
  output logic [LINE_W-1:0] ds_writedata,
  output logic              ds_writeenable,
  input  logic [LINE_W-1:0] ds_readdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
);

  state_e   state_q, state_d;
  cpu_req_t req_q, req_d;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [LINE_BIT_W-1:0] word_lsb;
  logic [TAG_W-1:0]      st_tag;
  logic                  st_valid;
  logic                  st_dirty;
  logic                  hit;

  logic tag_we, valid_we, valid_wr, dirty_we, dirty_wr;

  assign req_tag   = get_tag(req_q.addr);
  assign req_index = get_index(req_q.addr);
  assign word_lsb  = LINE_BIT_W'(get_word(req_q.addr)) << WORD_SH;
  assign hit       = st_valid && (st_tag == req_tag);

  cache_tag_store u_tags (
    .clk_i      (clk),
    .rst_ni     (reset),
    .index_i    (req_index),
    .tag_we_i   (tag_we),
    .tag_i      (req_tag),
    .valid_we_i (valid_we),
    .valid_i    (valid_wr),
    .dirty_we_i (dirty_we),
    .dirty_i    (dirty_wr),
    .tag_o      (st_tag),
    .valid_o    (st_valid),
    .dirty_o    (st_dirty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    ds_index       = '0;
    ds_writedata   = '0;
    ds_writeenable = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    tag_we         = 1'b0;
    valid_we       = 1'b0;
    valid_wr       = 1'b0;
    dirty_we       = 1'b0;
    dirty_wr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          req_d   = '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        ds_index = req_index;
        if (hit) begin
          cpu_resp_valid = 1'b1;
          if (req_q.we) begin
            // Read-modify-write of the whole line; only the addressed word changes.
            ds_writeenable                   = 1'b1;
            ds_writedata                     = ds_readdata;
            ds_writedata[word_lsb +: WORD_W] = req_q.wdata;
            dirty_we                         = 1'b1;
            dirty_wr                         = 1'b1;
          end else begin
            cpu_resp_rdata = ds_readdata[word_lsb +: WORD_W];
          end
          state_d = IDLE;
        end else if (st_valid && st_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end

      WRITEBACK: begin
        ds_index      = req_index;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {st_tag, req_index, OFFSET_W'(0)};
        mem_req_wdata = ds_readdata;
        if (mem_req_ready) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        ds_index      = req_index;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, OFFSET_W'(0)};
        if (mem_req_ready) begin
          state_d = REFILL;
        end
      end

      REFILL: begin
        ds_index = req_index;
        if (mem_resp_valid) begin
          // Line data and tag/valid/dirty land on the same edge; the retry then hits.
          ds_writeenable = 1'b1;
          ds_writedata   = mem_resp_data;
          tag_we         = 1'b1;
          valid_we       = 1'b1;
          valid_wr       = 1'b1;
          dirty_we       = 1'b1;
          dirty_wr       = 1'b0;
          state_d        = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Scoreboard bench for dm_cache_controller with a behavioural data store and memory.
module tb_dm_cache_controller;

  localparam logic [127:0] L1  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] L1M = {32'hDDDDDDDD, 32'hCAFEF00D, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] L2  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [9:0]   idx;
    logic [127:0] data;
  } ds_exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic [9:0]   ds_index;
  logic [127:0] ds_writedata, ds_readdata;
  logic         ds_writeenable;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data  = '0;

  logic [127:0] ds_mem [1024];
  mem_exp_t     mem_q[$];
  ds_exp_t      ds_q[$];
  logic [31:0]  resp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int mresp_cyc = 0;
  int resp_delay = 2;
  int pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  dm_cache_controller u_dut (
    .clk            (clk),
    .reset          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .ds_index       (ds_index),
    .ds_writedata   (ds_writedata),
    .ds_writeenable (ds_writeenable),
    .ds_readdata    (ds_readdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  // Data store: combinational read, synchronous write.
  assign ds_readdata = ds_mem[ds_index];
  always @(posedge clk) begin
    if (ds_writeenable) ds_mem[ds_index] <= ds_writedata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (a == 32'h0000_1230) return L1;
    if (a == 32'h0004_1230) return L2;
    return {4{a}};
  endfunction

  // Memory: fetch response resp_delay-1 cycles after the request handshake.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready && !mem_req_we) begin
        pend_cnt  = resp_delay;
        pend_addr = mem_req_addr;
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (pend_cnt == 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_line(pend_addr);
      end
      if (pend_cnt > 0) pend_cnt--;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_resp_valid) mresp_cyc = cyc;
      if (cpu_resp_valid) begin
        if (resp_q.size() == 0) check("cpu_resp_unexpected", 1'b1, 1'b0);
        else check("cpu_rdata", cpu_resp_rdata, resp_q.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_q.size() == 0) check("mem_req_unexpected", 1'b1, 1'b0);
        else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_req_we", mem_req_we, e.we);
          check("mem_req_addr", mem_req_addr, e.addr);
          if (e.we) check("mem_req_wdata", mem_req_wdata, e.wdata);
        end
      end
      if (ds_writeenable) begin
        if (ds_q.size() == 0) check("ds_write_unexpected", 1'b1, 1'b0);
        else begin
          ds_exp_t d;
          d = ds_q.pop_front();
          check("ds_index", ds_index, d.idx);
          check("ds_writedata", ds_writedata, d.data);
        end
      end
    end
  end

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 0;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        acc_cyc = cyc;
        got = 1;
        break;
      end
    end
    if (!got) check("req_accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    bit got = 0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin
        lat = cyc - acc_cyc;
        got = 1;
        break;
      end
    end
    if (!got) check("resp_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int  lat;
    bit  got;
    int  acc, rsp, rdy_bad;
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    mem_req_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_cpu_req_ready", cpu_req_ready, 1'b1);
    check("rst_cpu_resp_valid", cpu_resp_valid, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_ds_writeenable", ds_writeenable, 1'b0);
    check("rst_ds_index", ds_index, 10'h0);
    check("rst_cpu_resp_rdata", cpu_resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold read miss and refill.
    mem_q.push_back('{1'b0, 32'h0000_1230, '0});
    ds_q.push_back('{10'h123, L1});
    resp_q.push_back(32'hBBBBBBBB);
    issue_req(1'b0, 32'h0000_1234, '0);
    wait_resp(lat);
    check("cold_miss_latency", lat, 5);
    check("fill_to_resp_cycles", acc_cyc + lat - mresp_cyc, 1);

    // Write hit merges word 2.
    ds_q.push_back('{10'h123, L1M});
    resp_q.push_back(32'h0);
    issue_req(1'b1, 32'h0000_1238, 32'hCAFEF00D);
    wait_resp(lat);
    check("write_hit_latency", lat, 1);

    resp_q.push_back(32'hCAFEF00D);
    issue_req(1'b0, 32'h0000_1238, '0);
    wait_resp(lat);
    check("read_hit_latency", lat, 1);

    // Dirty conflict miss with a stalled writeback.
    mem_q.push_back('{1'b1, 32'h0000_1230, L1M});
    mem_q.push_back('{1'b0, 32'h0004_1230, '0});
    ds_q.push_back('{10'h123, L2});
    resp_q.push_back(32'h11111111);
    mem_req_ready = 1'b0;
    issue_req(1'b0, 32'h0004_1230, '0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("wb_req_seen", got, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("wb_stall_ctrl", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, 1'b1, 32'h0000_1230});
      check("wb_stall_wdata", mem_req_wdata, L1M);
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    wait_resp(lat);

    // Refilled line is clean: a further conflict must skip writeback.
    mem_q.push_back('{1'b0, 32'h0008_1230, '0});
    ds_q.push_back('{10'h123, {4{32'h0008_1230}}});
    resp_q.push_back(32'h0008_1230);
    issue_req(1'b0, 32'h0008_1230, '0);
    wait_resp(lat);
    check("clean_miss_latency", lat, 5);

    // Back-to-back hits with valid held high.
    repeat (3) resp_q.push_back(32'h0008_1230);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h0008_1234;
    acc = 0;
    rsp = 0;
    rdy_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_req_ready) acc++;
      if (cpu_resp_valid) begin
        rsp++;
        if (cpu_req_ready) rdy_bad++;
      end
      @(posedge clk);
      #1;
    end
    cpu_req_valid = 1'b0;
    check("b2b_accepts", acc, 3);
    check("b2b_responses", rsp, 3);
    check("b2b_ready_in_compare", rdy_bad, 0);

    // Reset while in REFILL; the late response must be ignored.
    resp_delay = 4;
    mem_q.push_back('{1'b0, 32'h0000_5670, '0});
    issue_req(1'b0, 32'h0000_5670, '0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        got = 1;
        break;
      end
    end
    check("refill_fetch_seen", got, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cpu_req_ready", cpu_req_ready, 1'b1);
    check("midrst_mem_req_valid", mem_req_valid, 1'b0);
    check("midrst_valid_cleared", u_dut.u_tags.valid_q == '0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_resp_valid) begin
        got = 1;
        check("stray_ds_writeenable", ds_writeenable, 1'b0);
        check("stray_cpu_resp_valid", cpu_resp_valid, 1'b0);
        break;
      end
    end
    check("stray_resp_seen", got, 1'b1);
    @(posedge clk);
    #1;
    check("post_stray_valid_clear", u_dut.u_tags.valid_q == '0, 1'b1);

    resp_delay = 2;
    mem_q.push_back('{1'b0, 32'h0000_5670, '0});
    ds_q.push_back('{10'h567, {4{32'h0000_5670}}});
    resp_q.push_back(32'h0000_5670);
    issue_req(1'b0, 32'h0000_5670, '0);
    wait_resp(lat);
    check("post_reset_miss_latency", lat, 5);

    repeat (3) @(negedge clk);
    check("mem_q_drained", mem_q.size(), 0);
    check("ds_q_drained", ds_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_cache_controller.md
Name: dm_cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller that drives the cache data store: index, write data and write enable out; combinational read data back.
- Accepts single-word CPU read/write requests and performs tag lookup in its own tag/valid/dirty arrays.
- On a miss it writes back a dirty victim and refills the line over a 128-bit memory-side valid/ready interface.
- Sits between the CPU load/store port and main memory.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_W, 10, line index width; 1024 lines, matches data store depth.
- LINE_W, 128, line width in bits; 4 words, 4-bit byte offset.
- WORD_W, 32, CPU data width.
- TAG_W: derived, not overridable; ADDR_W-INDEX_W-4 = 18.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  WORD_W  write word.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_rdata  out  WORD_W  read word; 0 for writes.
- ds_index  out  INDEX_W  data store index.
- ds_writedata  out  LINE_W  data store write line.
- ds_writeenable  out  1  data store write strobe.
- ds_readdata  in  LINE_W  data store read line, combinational from ds_index.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = line writeback, 0 = line fetch.
- mem_req_addr  out  ADDR_W  line address, bits [3:0] = 0.
- mem_req_wdata  out  LINE_W  writeback line.
- mem_resp_valid  in  1  fetched line valid; single pulse, no backpressure.
- mem_resp_data  in  LINE_W  fetched line.

Behaviour:
- Address split: tag = addr[31:14], index = addr[13:4], word = addr[3:2]; word 0 = line bits [31:0].
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All valid and dirty bits clear.
  - All outputs 0 except cpu_req_ready=1.
  - Tag array is not reset.
- States and transitions:
  - IDLE: cpu_req_ready=1. On cpu_req_valid, latch we/addr/wdata and go to COMPARE. No other outputs are active.
  - COMPARE: cpu_req_ready=0; ds_index = latched index.
    - Hit (valid & tag match), read: cpu_resp_valid=1, rdata = selected word of ds_readdata; go to IDLE.
    - Hit, write: ds_writeenable=1; ds_writedata = ds_readdata with the selected word replaced; set dirty; cpu_resp_valid=1; go to IDLE.
    - Miss with valid & dirty victim: go to WRITEBACK.
    - Miss otherwise: go to ALLOCATE.
  - WRITEBACK: mem_req_valid=1, we=1, addr = {stored tag, index, 4'b0}, wdata = ds_readdata. Hold all values stable until mem_req_ready, then go to ALLOCATE.
  - ALLOCATE: mem_req_valid=1, we=0, addr = {req tag, index, 4'b0}. On mem_req_ready go to REFILL.
  - REFILL: wait for mem_resp_valid. In that cycle: ds_writeenable=1, ds_writedata = mem_resp_data, tag ← req tag, valid=1, dirty=0. Then go to COMPARE; the retry is guaranteed to hit.
- Latency: a hit responds 1 cycle after acceptance. A clean miss takes 3 + memory handshake cycles minimum.
- Only one request is outstanding at a time; there is no hit-under-miss.
- mem_resp_valid outside REFILL is ignored.
- Reset mid-transaction: the transaction is abandoned and its late memory response is ignored.
- The valid/dirty update and the data write occur in the same clock edge.

Decomposition:
- dm_cache_pkg holds:
  - the width localparams (TAG_W, OFFSET_W=4);
  - the state enum {IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL};
  - functions get_tag/get_index/get_word.
- Sub-module cache_tag_store: 1024-entry tag array, plus valid/dirty vectors under async reset. Combinational read; one write port with separate tag/valid/dirty enables.

Test Plan:
- Cold read 0x0000_1234 → no hit; ALLOCATE issues mem_req_addr 0x0000_1230, we=0; respond with line 0xDDDD_CCCC_BBBB_AAAA_... → cpu_resp_rdata = word 1, one cycle after the REFILL-to-COMPARE transition.
- Write 0x0000_1238 with 0xCAFEF00D after that fill → hit, response 1 cycle after accept, ds_writeenable=1 at index 0x123. A following read returns 0xCAFEF00D.
- Read 0x0004_1230 (same index, different tag, victim dirty) → WRITEBACK to 0x0000_1230 with the merged line, then fetch 0x0004_1230; dirty=0 afterwards.
- Hold mem_req_ready=0 for 5 cycles in WRITEBACK → mem_req_* stable throughout; no state advance.
- Assert reset low while in REFILL → cpu_req_ready=1, all valid bits 0. A stray mem_resp_valid is ignored, and a subsequent read of the same address misses.
- Back-to-back read hits with cpu_req_valid held high → one accept every 2 cycles; cpu_req_ready low in COMPARE.
